ulpi_init_seq: RTL and testbench
================================

# ulpi_init_seq

Power-up configuration sequencer for the USB3300 ULPI PHY. After reset it walks a fixed table of (register address, value) pairs and feeds each one to the ULPI register-write stage through its WD/ADDR/DATA/busy handshake. It places the PHY in non-driving full-speed sniff mode, then reports completion to the capture logic. It sits directly upstream of the register-write stage and owns no ULPI bus pins except a read-only copy of DIR.

## Interface
Parameters:
- N_REGS, 3, number of table entries written (1..16)
- START_DELAY, 16, cycles idle after reset release before the first write (PHY PLL settle)
- TIMEOUT, 255, cycles allowed per write from WD pulse to busy falling (only with timeout enabled)

Ports:
- clk  in  1  ULPI 60 MHz clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- start  in  1  re-run request, sampled only in DONE or ERROR
- dir  in  1  ULPI DIR; high = PHY owns bus, no new write issued
- busy  in  1  busy from register-write stage
- wd  out  1  one-cycle write strobe to register-write stage
- addr  out  6  register address, stable from WD until busy falls
- data  out  8  register value, stable from WD until busy falls
- idx  out  4  index of current/last table entry
- done  out  1  level, high once all N_REGS writes completed
- error  out  1  level, high on write timeout (timeout build only)

## Operation
- Table (sub-module): 0: 0x0A←0x00 (OTG Control, pulldowns off); 1: 0x04←0x49 (Function Control: XcvrSelect=01, TermSelect=0, OpMode=01 non-driving, SuspendM=1); 2: 0x07←0x00 (Interface Control). Entries ≥ N_REGS never read.
- States: DELAY → ISSUE → WAIT_ACK → WAIT_DONE → (ISSUE | DONE); ERROR from WAIT_ACK/WAIT_DONE.
- DELAY: counter 0..START_DELAY-1; exits when count reaches START_DELAY-1.
- ISSUE: load addr/data from table[idx]; if dir=0 and busy=0, pulse wd for that cycle and go WAIT_ACK; otherwise stay, wd=0.
- WAIT_ACK: wait busy=1; then WAIT_DONE.
- WAIT_DONE: wait busy=0; if idx=N_REGS-1 go DONE, else idx+1 and ISSUE.
- DONE: done=1; start=1 → clear done, idx=0, ISSUE (no delay).
- ERROR: error=1, wd=0, addr/data held; start=1 → clear error, idx=0, ISSUE.
- dir rising during WAIT_ACK/WAIT_DONE ignored (register-write stage handles aborts).

## Timing
- Reset values: wd=0, addr=0, data=0, idx=0, done=0, error=0, state DELAY, counters 0.
- rst low mid-sequence: immediate return to reset values; next rst release restarts full sequence including DELAY.
- First wd: cycle START_DELAY after rst release if dir=0, busy=0.
- wd high exactly one cycle per entry; never two wd without intervening busy high→low.
- Next ISSUE one cycle after busy falls; back-to-back entries therefore spaced by writer latency + 2 cycles.
- done rises the cycle after final busy fall.
- start held high in DONE re-runs once per DONE entry, not continuously (edge irrelevant; level sampled on DONE/ERROR only).

## Configuration
- ULPI_INIT_TIMEOUT_EN defined: 8-bit counter cleared on wd, increments in WAIT_ACK/WAIT_DONE; reaching TIMEOUT → ERROR next cycle.
- Not defined: no counter, error tied 0, sequencer waits indefinitely on busy; ERROR state unreachable.

## Structure
- Shared header ulpi_defs.vh: ULPI register address constants (FUNC_CTRL 0x04, IFC_CTRL 0x07, OTG_CTRL 0x0A), Function Control bit-field constants, state encodings.
- One sub-module: ulpi_init_rom (combinational idx → {addr, data}), so table changes do not touch FSM.

## Test plan
- Reset release, writer model busy 3 cycles after wd → wd at cycles 16, ~22, ~28; addr/data 0x0A/0x00, 0x04/0x49, 0x07/0x00; done=1 after third busy fall.
- dir=1 held over cycle 16..25 → first wd delayed to first cycle with dir=0.
- rst low during second write → all outputs 0; after release, full sequence from entry 0 with 16-cycle delay.
- Timeout build, busy never rises → error=1 at wd+TIMEOUT+1, wd stays 0; start pulse → error clears, entry 0 reissued.
- In DONE, start=1 one cycle → three writes repeat without delay; done low during re-run, high again after.
- Non-timeout build, busy stuck high → FSM waits in WAIT_DONE indefinitely, error=0.

Source files
------------

// File: rtl/ulpi_init_seq_pkg.sv
// Shared definitions for the USB3300 power-up sequencer: ULPI register map,
// Function Control bit-field helpers and the sequencer state encoding.
package ulpi_init_seq_pkg;

  localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
  localparam logic [5:0] REG_IFC_CTRL  = 6'h07;
  localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;

  localparam logic [1:0] XCVR_FS       = 2'b01;
  localparam logic [1:0] OPMODE_NONDRV = 2'b01;

  // Function Control layout: [6] SuspendM, [5] Reset, [4:3] OpMode, [2] TermSelect, [1:0] XcvrSelect
  function automatic logic [7:0] func_ctrl(input logic [1:0] xcvr, input logic term,
                                           input logic [1:0] opmode, input logic phy_rst,
                                           input logic suspendm);
    return {1'b0, suspendm, phy_rst, opmode, term, xcvr};
  endfunction

  typedef enum logic [2:0] {
    S_DELAY     = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

endpackage

// File: rtl/ulpi_init_seq_if.sv
// Write handshake between the init sequencer and the ULPI register-write stage.
interface ulpi_init_seq_if;
  logic       wd;
  logic [5:0] addr;
  logic [7:0] data;
  logic       busy;

  modport master (output wd, output addr, output data, input busy);
  modport slave  (input wd, input addr, input data, output busy);
endinterface

// File: rtl/ulpi_init_rom.sv
// Power-up register table: idx -> {addr, data}; unused slots read as zero.
import ulpi_init_seq_pkg::*;

module ulpi_init_rom (
  input  logic [3:0] idx,
  output logic [5:0] addr,
  output logic [7:0] data
);

  always_comb begin
    addr = '0;
    data = '0;
    case (idx)
      4'd0: begin
        addr = REG_OTG_CTRL;
        data = 8'h00;
      end
      4'd1: begin
        // Full-speed transceiver, non-driving, not suspended: pure sniff mode
        addr = REG_FUNC_CTRL;
        data = func_ctrl(XCVR_FS, 1'b0, OPMODE_NONDRV, 1'b0, 1'b1);
      end
      4'd2: begin
        addr = REG_IFC_CTRL;
        data = 8'h00;
      end
      default: begin
        addr = '0;
        data = '0;
      end
    endcase
  end

endmodule

// File: rtl/ulpi_init_seq.sv
// USB3300 power-up sequencer: waits for PLL settle, then writes the init table.
// Optional write timeout with ERROR state when ULPI_INIT_TIMEOUT_EN is defined.
import ulpi_init_seq_pkg::*;

module ulpi_init_seq #(
  parameter int N_REGS      = 3,
  parameter int START_DELAY = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dir,
  ulpi_init_seq_if.master wr,
  output logic [3:0]      idx,
  output logic            done,
  output logic            error
);

  localparam logic [15:0] DLY_LAST = 16'(START_DELAY - 1);
  localparam logic [3:0]  IDX_LAST = 4'(N_REGS - 1);

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [15:0] dly_reg, dly_next;
  logic [5:0]  addr_reg;
  logic [7:0]  data_reg;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        wd;
  logic        timed_out;

  ulpi_init_rom u_rom (
    .idx  (idx_reg),
    .addr (rom_addr),
    .data (rom_data)
  );

`ifdef ULPI_INIT_TIMEOUT_EN
  logic [7:0] to_reg, to_next;

  always_comb begin
    to_next = to_reg;
    if (wd)
      to_next = 8'd0;
    else if (state_reg == S_WAIT_ACK || state_reg == S_WAIT_DONE)
      to_next = to_reg + 8'd1;
  end

  // Fires in the cycle the count would reach TIMEOUT, so ERROR lands at wd+TIMEOUT+1
  assign timed_out = (to_reg == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_reg <= 8'd0;
    else
      to_reg <= to_next;
  end

  assign error = (state_reg == S_ERROR);
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign timed_out      = 1'b0;
  assign error          = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    dly_next   = dly_reg;
    wd         = 1'b0;
    case (state_reg)
      S_DELAY: begin
        if (dly_reg == DLY_LAST)
          state_next = S_ISSUE;
        else
          dly_next = dly_reg + 16'd1;
      end
      S_ISSUE: begin
        if (!dir && !wr.busy) begin
          wd         = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (wr.busy)
          state_next = S_WAIT_DONE;
        else if (timed_out)
          state_next = S_ERROR;
      end
      S_WAIT_DONE: begin
        if (!wr.busy) begin
          if (idx_reg == IDX_LAST) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + 4'd1;
            state_next = S_ISSUE;
          end
        end else if (timed_out) begin
          state_next = S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          idx_next   = 4'd0;
          state_next = S_ISSUE;
        end
      end
      default: state_next = S_DELAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_DELAY;
      idx_reg   <= 4'd0;
      dly_reg   <= 16'd0;
      addr_reg  <= 6'd0;
      data_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      dly_reg   <= dly_next;
      if (wd) begin
        addr_reg <= rom_addr;
        data_reg <= rom_data;
      end
    end
  end

  // Table value is shown live while issuing, then latched until the next write
  assign wr.wd   = wd;
  assign wr.addr = (state_reg == S_ISSUE) ? rom_addr : addr_reg;
  assign wr.data = (state_reg == S_ISSUE) ? rom_data : data_reg;
  assign idx     = idx_reg;
  assign done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_ulpi_init_seq.sv
// Scoreboard bench for ulpi_init_seq with a randomized register-writer model.
module tb_ulpi_init_seq;

  localparam int N_REGS = 3;
  localparam int SD     = 16;
  localparam int TO     = 20;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
    logic [3:0] i;
  } exp_t;

  logic clk, rst, start, dir;
  logic [3:0] idx;
  logic done, error;

  ulpi_init_seq_if ifc ();

  ulpi_init_seq #(.N_REGS(N_REGS), .START_DELAY(SD), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dir   (dir),
    .wr    (ifc),
    .idx   (idx),
    .done  (done),
    .error (error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dir_mode = 0;      // 0 low, 1 high, 2 random
  int wr_mode = 0;       // 0 normal, 1 never busy, 2 busy stuck high
  int exp_first_wd = -1;
  int exp_done_cyc = -1;
  int last_wd_cyc = 0;
  int wd_cnt = 0;
  exp_t expq[$];

  // Reference table from the PHY register map: OTG Ctrl, Function Ctrl, Interface Ctrl
  logic [5:0] model_addr [N_REGS];
  logic [7:0] model_data [N_REGS];
  initial begin
    model_addr[0] = 6'h0A; model_data[0] = 8'h00;
    model_addr[1] = 6'h04; model_data[1] = 8'((1 << 6) | (1 << 3) | 1);
    model_addr[2] = 6'h07; model_data[2] = 8'h00;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_run();
    for (int i = 0; i < N_REGS; i++)
      expq.push_back('{model_addr[i], model_data[i], 4'(i)});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wd"},    int'(ifc.wd),   0);
    chk({tag, "_addr"},  int'(ifc.addr), 0);
    chk({tag, "_data"},  int'(ifc.data), 0);
    chk({tag, "_idx"},   int'(idx),      0);
    chk({tag, "_done"},  int'(done),     0);
    chk({tag, "_error"}, int'(error),    0);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_reached", int'(done), 1);
    chk("queue_drained", expq.size(), 0);
  endtask

  task automatic start_run();
    @(posedge clk); #1;
    push_run();
    start = 1'b1;
    exp_first_wd = (dir_mode == 0) ? cyc + 1 : -1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_clr", int'(done), 0);
    chk("error_clr", int'(error), 0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    dir = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (dir_mode)
        0:       dir = 1'b0;
        1:       dir = 1'b1;
        default: dir = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Register-write stage model: busy rises lat cycles after wd, holds for hold cycles
  initial begin
    int lat, hold;
    ifc.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && ifc.wd && wr_mode != 1) begin
        lat  = $urandom_range(1, 4);
        hold = $urandom_range(1, 3);
        repeat (lat) @(posedge clk);
        #1 ifc.busy = 1'b1;
        if (wr_mode == 2) begin
          while (wr_mode == 2) @(posedge clk);
          #1;
        end else begin
          repeat (hold) @(posedge clk);
          #1;
        end
        ifc.busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every write strobe, checks handshake rules
  initial begin
    exp_t e;
    logic pending, prev_busy;
    logic [5:0] hold_a;
    logic [7:0] hold_d;
    pending = 1'b0;
    prev_busy = 1'b0;
    hold_a = '0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pending = 1'b0;
        exp_done_cyc = -1;
      end else begin
        if (exp_done_cyc == cyc) begin
          chk("done_after_last_fall", int'(done), 1);
          exp_done_cyc = -1;
        end
        if (error) pending = 1'b0;
        if (ifc.wd) begin
          chk("wd_with_dir", int'(dir), 0);
          chk("wd_overlap", int'(pending), 0);
          if (expq.size() == 0) begin
            chk("unexpected_wd", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("wd_addr", int'(ifc.addr), int'(e.a));
            chk("wd_data", int'(ifc.data), int'(e.d));
            chk("wd_idx",  int'(idx),      int'(e.i));
          end
          if (exp_first_wd >= 0) begin
            chk("first_wd_cycle", cyc, exp_first_wd);
            exp_first_wd = -1;
          end
          $display("wd #%0d cyc %0d idx %0d addr %02h data %02h", wd_cnt, cyc, idx, ifc.addr, ifc.data);
          pending = 1'b1;
          hold_a = ifc.addr;
          hold_d = ifc.data;
          last_wd_cyc = cyc;
          wd_cnt++;
        end else if (pending) begin
          if (ifc.addr != hold_a) chk("addr_stable", int'(ifc.addr), int'(hold_a));
          if (ifc.data != hold_d) chk("data_stable", int'(ifc.data), int'(hold_d));
          if (prev_busy && !ifc.busy) begin
            pending = 1'b0;
            if (expq.size() == 0) exp_done_cyc = cyc + 1;
          end
        end
      end
      prev_busy = ifc.busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int rel, base;
    rst = 1'b0;
    start = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    // Basic power-up run
    @(posedge clk); #1;
    push_run();
    rst = 1'b1;
    exp_first_wd = cyc + SD;
    wait_done(400);

    // Re-run from DONE without delay
    start_run();
    wait_done(400);

    // DIR held high across the first issue slot
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    dir_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    push_run();
    rst = 1'b1;
    rel = cyc;
    exp_first_wd = rel + SD + 10;
    repeat (SD + 10) @(posedge clk);
    #1 dir_mode = 0;
    wait_done(400);

    // Reset asserted during the second write
    base = wd_cnt;
    start_run();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wd_cnt >= base + 2) break;
    end
    chk("second_wd_seen", wd_cnt - base, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    expq.delete();
    repeat (3) @(posedge clk);
    #1;
    push_run();
    rst = 1'b1;
    exp_first_wd = cyc + SD;
    wait_done(400);

    // Randomized DIR noise across several re-runs
    dir_mode = 2;
    for (int r = 0; r < 4; r++) begin
      start_run();
      wait_done(800);
    end
    dir_mode = 0;

`ifdef ULPI_INIT_TIMEOUT_EN
    // Writer never acknowledges: ERROR after TIMEOUT, then recover with start
    wr_mode = 1;
    start_run();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (error) break;
    end
    chk("timeout_error", int'(error), 1);
    chk("timeout_cycle", cyc, last_wd_cyc + TO + 1);
    chk("timeout_no_wd", int'(ifc.wd), 0);
    wr_mode = 0;
    expq.delete();
    start_run();
    wait_done(400);
`else
    // Busy stuck high: sequencer must wait indefinitely without error
    wr_mode = 2;
    start_run();
    repeat (300) @(negedge clk);
    chk("stuck_error", int'(error), 0);
    chk("stuck_done", int'(done), 0);
    chk("stuck_idx", int'(idx), 0);
    chk("stuck_wds", expq.size(), N_REGS - 1);
    wr_mode = 0;
    wait_done(400);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
